ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
Pipeline stage directly downstream of the ALU. Captures each ALU beat (ALU_result, sig_branch, store data, destination register, opcode) into a small FIFO and presents it to the memory stage over a valid/ready handshake. Raises a one-cycle branch-redirect pulse for taken branches. Decouples ALU timing from memory-stage backpressure and supports pipeline flush.

Parameters:
DATA_W, 32, width of ALU_result and store data
DEPTH, 2, FIFO entries; power of two, at least 2
BEQ_OP, 6'b000100, opcode treated as a branch
BNE_OP, 6'b000101, opcode treated as a branch

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush
in_valid  input  1  ALU beat valid
in_ready  output  1  stage can accept a beat
ALU_result  input  DATA_W  result from ALU
sig_branch  input  1  branch condition from ALU
rt_content  input  DATA_W  store data
rd_addr  input  5  destination register
opcode  input  6  instruction opcode
out_valid  output  1  head entry valid
out_ready  input  1  memory stage accepts head
out_alu_result  output  DATA_W  head ALU_result
out_store_data  output  DATA_W  head rt_content
out_rd_addr  output  5  head rd_addr
out_opcode  output  6  head opcode
out_branch  output  1  head masked branch flag
branch_taken  output  1  one-cycle redirect pulse
occupancy  output  log2(DEPTH)+1  entries held

Behaviour:
- Reset (rst_n low, asynchronous): count, read/write pointers, branch_taken, out_valid and all out_* data fields = 0. in_ready is forced 0 while rst_n is low and equals 1 in the first cycle after release.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH), decoded from registered count. No combinational path from in_valid or out_ready to in_ready.
- out_valid = (count != 0). out_* fields are driven from the head entry and stay stable while out_valid & !out_ready.
- Latency: a beat accepted in cycle N appears on out_* in cycle N+1 at the earliest. There is no same-cycle bypass.
- Push and pop in the same cycle: count is unchanged and both pointers advance. When full, in_ready = 0, so push+pop is impossible. When empty, out_valid = 0, so pop is impossible.
- Pointers wrap modulo DEPTH.
- Branch flag = sig_branch & (opcode == BEQ_OP | opcode == BNE_OP). It is stored per entry and output as out_branch. sig_branch with a non-branch opcode is ignored.
- branch_taken is registered high for exactly one cycle following a push whose branch flag = 1. The beat is still enqueued.
- flush (synchronous, highest priority):
  - Next cycle: count = 0, both pointers = 0, out_valid = 0.
  - A push or pop in the flush cycle has no effect. The beat offered that cycle is dropped.
  - branch_taken is not raised for a beat dropped by flush.
- Reset asserted mid-transfer discards all contents immediately. There is no partial state after release.

Optional Feature:
EX_MEM_PERF_EN.
- Defined: adds outputs perf_beats[31:0] (count of pushes) and perf_branches[31:0] (count of branch_taken pulses). Both are cleared by reset, unaffected by flush, and wrap from 0xFFFFFFFF to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset mid-operation: 2 entries held, pull rst_n low between edges -> out_valid, occupancy, branch_taken = 0 immediately; in_ready = 1 first cycle after release.
- Single beat: ALU_result = 27, rd_addr = 5, opcode = 0, out_ready = 1 -> out_valid = 1 next cycle with out_alu_result = 27, out_rd_addr = 5; occupancy returns to 0 the following cycle.
- Backpressure: out_ready = 0, push ALU_result 30 then 45 -> in_ready = 0, occupancy = 2; third beat (1) held on input. Raise out_ready -> outputs 30, 45, 1 in order with no loss or duplication.
- Branch: opcode = 000100, sig_branch = 1 -> branch_taken high exactly one cycle, out_branch = 1. Opcode = 000000, sig_branch = 1 -> no pulse, out_branch = 0.
- Flush: full buffer, in_valid = 1 with ALU_result = 99, flush = 1 -> next cycle occupancy = 0, out_valid = 0; 99 never appears on the output.
- With EX_MEM_PERF_EN: push 3 beats including 1 taken branch, then flush -> perf_beats = 3, perf_branches = 1, both unchanged by the flush.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: buffers ALU beats in a small FIFO and hands them to the memory stage; flags taken branches.
// Latency: one cycle minimum from accepted beat to out_*; branch_taken follows the accepting edge by one cycle.
// Backpressure: in_ready drops when DEPTH entries are held (decoded from registered count only); flush empties the buffer.
// Optional build macro EX_MEM_PERF_EN adds perf_beats / perf_branches counters.
module ex_mem_stage #(
    parameter int          DATA_W = 32,
    parameter int          DEPTH  = 2,
    parameter logic [5:0]  BEQ_OP = 6'b000100,
    parameter logic [5:0]  BNE_OP = 6'b000101
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         ALU_result,
    input  logic                      sig_branch,
    input  logic [DATA_W-1:0]         rt_content,
    input  logic [4:0]                rd_addr,
    input  logic [5:0]                opcode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_alu_result,
    output logic [DATA_W-1:0]         out_store_data,
    output logic [4:0]                out_rd_addr,
    output logic [5:0]                out_opcode,
    output logic                      out_branch,
    output logic                      branch_taken,
    output logic [$clog2(DEPTH):0]    occupancy
`ifdef EX_MEM_PERF_EN
    ,
    output logic [31:0]               perf_beats,
    output logic [31:0]               perf_branches
`endif
);

    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        logic [4:0]        rd_addr;
        logic [5:0]        opcode;
        logic              branch;
    } beat_t;

    beat_t          mem [DEPTH];
    beat_t          wr_dat;
    beat_t          head;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    count;
    logic           push;
    logic           pop;
    logic           is_branch;

    // Branch flag only counts for real branch opcodes; sig_branch on anything else is noise.
    assign is_branch = sig_branch & ((opcode == BEQ_OP) | (opcode == BNE_OP));

    assign wr_dat = '{alu_result: ALU_result,
                      store_data: rt_content,
                      rd_addr:    rd_addr,
                      opcode:     opcode,
                      branch:     is_branch};

    // Ready depends only on registered count (and reset), never on in_valid or out_ready.
    assign in_ready  = rst_n & (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign occupancy = count;

    assign head           = mem[rd_ptr];
    assign out_alu_result = head.alu_result;
    assign out_store_data = head.store_data;
    assign out_rd_addr    = head.rd_addr;
    assign out_opcode     = head.opcode;
    assign out_branch     = head.branch;

    // Entry storage and pointers; flush drops the offered beat and rewinds both pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Redirect pulse: one cycle after a branch beat is actually enqueued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_taken <= 1'b0;
        end else begin
            branch_taken <= push & is_branch & ~flush;
        end
    end

`ifdef EX_MEM_PERF_EN
    // Free-running event counters; survive flush, wrap naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_beats    <= '0;
            perf_branches <= '0;
        end else begin
            if (push & ~flush) begin
                perf_beats <= perf_beats + 32'd1;
            end
            if (push & is_branch & ~flush) begin
                perf_branches <= perf_branches + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, single beat, backpressure ordering, branch pulse, flush, reset mid-transfer.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Optional perf counter scenario is built when EX_MEM_PERF_EN is defined.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ALU_result;
    logic        sig_branch;
    logic [31:0] rt_content;
    logic [4:0]  rd_addr;
    logic [5:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_rd_addr;
    logic [5:0]  out_opcode;
    logic        out_branch;
    logic        branch_taken;
    logic [1:0]  occupancy;
`ifdef EX_MEM_PERF_EN
    logic [31:0] perf_beats;
    logic [31:0] perf_branches;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .ALU_result     (ALU_result),
        .sig_branch     (sig_branch),
        .rt_content     (rt_content),
        .rd_addr        (rd_addr),
        .opcode         (opcode),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alu_result (out_alu_result),
        .out_store_data (out_store_data),
        .out_rd_addr    (out_rd_addr),
        .out_opcode     (out_opcode),
        .out_branch     (out_branch),
        .branch_taken   (branch_taken),
        .occupancy      (occupancy)
`ifdef EX_MEM_PERF_EN
        ,
        .perf_beats     (perf_beats),
        .perf_branches  (perf_branches)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ALU_result = '0; sig_branch = 1'b0; rt_content = '0; rd_addr = '0; opcode = '0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rst_occupancy got=%0d want=0", occupancy); end
        total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL rst_branch_taken got=%0b want=0", branch_taken); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready_low got=%0b want=0", in_ready); end
        total++; if (out_alu_result !== 32'd0) begin bad++; $display("FAIL rst_out_alu got=%0d want=0", out_alu_result); end
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready_release got=%0b want=1", in_ready); end
        step();
    endtask

    task automatic test_single();
        out_ready = 1'b1; in_valid = 1'b1; ALU_result = 32'd27; rd_addr = 5'd5; opcode = 6'd0;
        rt_content = 32'hABCD; sig_branch = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_no_bypass got=%0b want=0", out_valid); end
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid got=%0b want=1", out_valid); end
        total++; if (out_alu_result !== 32'd27) begin bad++; $display("FAIL single_alu got=%0d want=27", out_alu_result); end
        total++; if (out_rd_addr !== 5'd5) begin bad++; $display("FAIL single_rd got=%0d want=5", out_rd_addr); end
        total++; if (out_store_data !== 32'hABCD) begin bad++; $display("FAIL single_store got=%h want=abcd", out_store_data); end
        step();
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL single_drain got=%0d want=0", occupancy); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_bp [3];
        int          idx;
        logic        accepted;
        exp_bp = '{32'd30, 32'd45, 32'd1};
        out_ready = 1'b0; in_valid = 1'b1; ALU_result = 32'd30;
        step();
        ALU_result = 32'd45;
        step();
        ALU_result = 32'd1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b want=0", in_ready); end
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL bp_occupancy got=%0d want=2", occupancy); end
        step();
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL bp_held_occ got=%0d want=2", occupancy); end
        total++; if (out_alu_result !== 32'd30) begin bad++; $display("FAIL bp_head_stable got=%0d want=30", out_alu_result); end
        out_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            accepted = in_valid & in_ready;
            if (out_valid && out_ready) begin
                total++;
                if (out_alu_result !== exp_bp[idx]) begin
                    bad++; $display("FAIL bp_order[%0d] got=%0d want=%0d", idx, out_alu_result, exp_bp[idx]);
                end
                idx++;
            end
            step();
            if (accepted) in_valid = 1'b0;
        end
        total++; if (idx != 3) begin bad++; $display("FAIL bp_timeout got=%0d beats want=3", idx); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%0b want=0", out_valid); end
        in_valid = 1'b0;
    endtask

    task automatic test_branch();
        out_ready = 1'b0; in_valid = 1'b1; ALU_result = 32'd7; opcode = 6'b000100; sig_branch = 1'b1;
        total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL br_pre got=%0b want=0", branch_taken); end
        step();
        in_valid = 1'b0;
        total++; if (branch_taken !== 1'b1) begin bad++; $display("FAIL br_pulse got=%0b want=1", branch_taken); end
        total++; if (out_branch !== 1'b1) begin bad++; $display("FAIL br_out_branch got=%0b want=1", out_branch); end
        step();
        total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL br_one_cycle got=%0b want=0", branch_taken); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b1; ALU_result = 32'd8; opcode = 6'b000000; sig_branch = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL br_nonbranch_pulse got=%0b want=0", branch_taken); end
        total++; if (out_branch !== 1'b0) begin bad++; $display("FAIL br_nonbranch_flag got=%0b want=0", out_branch); end
        total++; if (out_alu_result !== 32'd8) begin bad++; $display("FAIL br_nonbranch_enq got=%0d want=8", out_alu_result); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0; sig_branch = 1'b0; opcode = 6'd0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; ALU_result = 32'd10;
        step();
        ALU_result = 32'd11;
        step();
        ALU_result = 32'd99; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL fl_occupancy got=%0d want=0", occupancy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_out_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_in_ready got=%0b want=1", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_ghost got=%0d want=none", out_alu_result); end
        end
        in_valid = 1'b1; ALU_result = 32'd99; opcode = 6'b000100; sig_branch = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; sig_branch = 1'b0; opcode = 6'd0;
        total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL fl_drop_pulse got=%0b want=0", branch_taken); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL fl_drop_occ got=%0d want=0", occupancy); end
        in_valid = 1'b1; ALU_result = 32'd55;
        step();
        in_valid = 1'b0;
        total++; if (out_alu_result !== 32'd55 || out_valid !== 1'b1) begin
            bad++; $display("FAIL fl_after got=%0d/%0b want=55/1", out_alu_result, out_valid);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; ALU_result = 32'd4; opcode = 6'd0; sig_branch = 1'b0;
        step();
        ALU_result = 32'd5; opcode = 6'b000101; sig_branch = 1'b1;
        step();
        in_valid = 1'b0; sig_branch = 1'b0; opcode = 6'd0;
        total++; if (occupancy !== 2'd2 || branch_taken !== 1'b1) begin
            bad++; $display("FAIL rm_setup got=%0d/%0b want=2/1", occupancy, branch_taken);
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_out_valid got=%0b want=0", out_valid); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rm_occupancy got=%0d want=0", occupancy); end
        total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL rm_branch_taken got=%0b want=0", branch_taken); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_in_ready got=%0b want=1", in_ready); end
        step();
        total++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_alu_result !== 32'd0) begin
            bad++; $display("FAIL rm_clean got=%0d/%0b/%0d want=0/0/0", occupancy, out_valid, out_alu_result);
        end
    endtask

`ifdef EX_MEM_PERF_EN
    task automatic test_perf();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        total++; if (perf_beats !== 32'd0 || perf_branches !== 32'd0) begin
            bad++; $display("FAIL perf_reset got=%0d/%0d want=0/0", perf_beats, perf_branches);
        end
        out_ready = 1'b1; in_valid = 1'b1;
        ALU_result = 32'd1; opcode = 6'd0; sig_branch = 1'b0;
        step();
        ALU_result = 32'd2; opcode = 6'b000100; sig_branch = 1'b1;
        step();
        ALU_result = 32'd3; opcode = 6'd0; sig_branch = 1'b1;
        step();
        in_valid = 1'b0; sig_branch = 1'b0;
        total++; if (perf_beats !== 32'd3 || perf_branches !== 32'd1) begin
            bad++; $display("FAIL perf_count got=%0d/%0d want=3/1", perf_beats, perf_branches);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (perf_beats !== 32'd3 || perf_branches !== 32'd1) begin
            bad++; $display("FAIL perf_flush got=%0d/%0d want=3/1", perf_beats, perf_branches);
        end
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_branch();
        test_flush();
        test_reset_mid();
`ifdef EX_MEM_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
